pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 5-stage CPU. It drives the go/clear pairs of the four inter-stage buffers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable. It resolves load-use hazards, taken-branch flushes, memory-busy freezes and syscall halt/resume. It also keeps cycle, stall and flush statistics counters.

Parameters:
CNT_W, 32, width of each statistics counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous active-high reset.
id_rs  in  5  rs field of the instruction in ID.
id_rt  in  5  rt field of the instruction in ID.
id_rs_used  in  1  the ID instruction reads rs.
id_rt_used  in  1  the ID instruction reads rt.
ex_mem_read  in  1  the EX instruction is a load.
ex_rw  in  5  destination register of the EX instruction.
ex_branch_taken  in  1  the EX instruction redirects the PC.
mem_busy  in  1  data memory is not ready; freeze the whole pipe.
syscall_halt  in  1  MEM_WB holds a halting syscall (decoded externally).
resume  in  1  single-cycle pulse to leave the halt state.
go_pc  out  1  PC register load enable.
go_if_id, go_id_ex, go_ex_mem, go_mem_wb  out  1 each  buffer load enables.
clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb  out  1 each  buffer bubble-insert selects.
halted  out  1  registered; high while in the HALT state.
cycle_cnt, stall_cnt, flush_cnt  out  CNT_W each  statistics counters.

Behaviour:
- States: RUN and HALT. Reset puts the block in RUN with halted=0 and all counters=0.
- Control outputs (go_*, clear_*) are combinational from the current state and the inputs. Zero added latency: they take effect at the next posedge.
- Default in RUN with no events: all go_*=1, all clear_*=0.
- Load-use condition (luse): ex_mem_read && ex_rw!=0 && ((id_rs_used && id_rs==ex_rw) || (id_rt_used && id_rt==ex_rw)).
- Priority in RUN, highest first:
  1. syscall_halt: all go_*=0, all clear_*=0. State goes to HALT next cycle.
  2. mem_busy: all go_*=0, all clear_*=0. Pure freeze.
  3. ex_branch_taken: all go_*=1, clear_if_id=1, clear_id_ex=1. flush_cnt+1.
  4. luse: go_pc=0, go_if_id=0, go_id_ex=1, clear_id_ex=1, go_ex_mem=1, go_mem_wb=1. Inserts one bubble; stall_cnt+1.
- A branch coincident with luse is a flush only; stall_cnt does not increment. The hazard clears the next cycle because the load has advanced.
- luse persisting under mem_busy: the freeze wins and no stall is counted. The stall is applied on the first non-busy cycle.
- cycle_cnt increments every cycle in RUN, including freeze and halt-entry cycles, and is held in HALT. All counters wrap modulo 2^CNT_W silently.
- HALT state, resume=0: all go_*=0, all clear_*=0; halted=1.
- HALT state, resume=1: go_mem_wb=1 and clear_mem_wb=1, all other go_*=0. This squashes the syscall so it does not re-trigger the halt. State returns to RUN next cycle, and halted=0 from that cycle.
- resume in RUN is ignored.
- rst has priority over every input in every state. Reset mid-stall or in HALT returns to RUN with counters zeroed. During the rst cycle, outputs follow RUN-state decoding of the current inputs; the buffers are reset by their own logic.
- Register 0 never causes a hazard (the ex_rw!=0 term).

Test Plan:
1. Reset then 10 idle cycles -> all go=1, all clear=0; cycle_cnt=10, stall_cnt=flush_cnt=0, halted=0.
2. ex_mem_read=1, ex_rw=8, id_rs=8, id_rs_used=1 for one cycle -> go_pc=0, go_if_id=0, clear_id_ex=1; stall_cnt=1. Repeat with ex_rw=0 -> no stall.
3. ex_branch_taken=1 together with the step-2 load-use inputs -> clear_if_id=1, clear_id_ex=1, go_pc=1; flush_cnt=1, stall_cnt unchanged.
4. mem_busy=1 for 3 cycles while luse is asserted -> all go=0, no clear, stall_cnt unchanged, cycle_cnt+3. Then mem_busy=0 -> one stall, stall_cnt+1.
5. syscall_halt=1 -> all go=0 that cycle; halted=1 next cycle; cycle_cnt frozen for 5 cycles. Pulse resume -> go_mem_wb=1, clear_mem_wb=1, others 0; halted=0 next cycle; normal flow resumes.
6. rst asserted while in HALT with nonzero counters -> next cycle RUN, halted=0, all counters 0. Separately, preload stall_cnt to all-ones via repeated stalls (CNT_W=4 build) -> wraps to 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline sequencer and the datapath it steers.
// The slave side is the sequencer: it reads hazard/status inputs and
// drives buffer enables, bubble selects, the halt flag and statistics.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  // Hazard and status inputs seen by the sequencer
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_mem_read;
  logic [4:0]       ex_rw;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             syscall_halt;
  logic             resume;

  // Pipeline steering outputs
  logic             go_pc;
  logic             go_if_id;
  logic             go_id_ex;
  logic             go_ex_mem;
  logic             go_mem_wb;
  logic             clear_if_id;
  logic             clear_id_ex;
  logic             clear_ex_mem;
  logic             clear_mem_wb;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rw,
           ex_branch_taken, mem_busy, syscall_halt, resume,
    input  go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
           clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb,
           halted, cycle_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_mem_read, ex_rw,
           ex_branch_taken, mem_busy, syscall_halt, resume,
    output go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
           clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb,
           halted, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: decodes load-use stalls,
// branch flushes, memory freezes and syscall halt/resume into the
// go/clear pairs of the inter-stage buffers, and keeps statistics.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  // go vector order: pc, if_id, id_ex, ex_mem, mem_wb
  // clear vector order: if_id, id_ex, ex_mem, mem_wb
  logic [4:0] go_d;
  logic [3:0] clear_d;
  logic       luse;
  logic       run_dec;
  logic       do_stall;
  logic       do_flush;

  // Load-use hazard; r0 is hard-wired so a load into it never stalls
  assign luse = bus.ex_mem_read && (bus.ex_rw != 5'd0) &&
                ((bus.id_rs_used && (bus.id_rs == bus.ex_rw)) ||
                 (bus.id_rt_used && (bus.id_rt == bus.ex_rw)));

  // While rst is high the outputs decode as RUN whatever the state
  assign run_dec = rst || (state_q == RUN);

  // Prioritised steering decode and next-state selection
  always_comb begin
    go_d     = 5'b11111;
    clear_d  = 4'b0000;
    do_stall = 1'b0;
    do_flush = 1'b0;
    state_d  = state_q;
    if (run_dec) begin
      if (bus.syscall_halt) begin
        go_d    = 5'b00000;
        state_d = HALT;
      end else if (bus.mem_busy) begin
        go_d = 5'b00000;
      end else if (bus.ex_branch_taken) begin
        // Flush squashes the younger instructions, so any load-use
        // stall against them is moot and not counted
        clear_d  = 4'b1100;
        do_flush = 1'b1;
      end else if (luse) begin
        go_d     = 5'b00111;
        clear_d  = 4'b0100;
        do_stall = 1'b1;
      end
    end else begin
      go_d = 5'b00000;
      if (bus.resume) begin
        // Retire the syscall as a bubble so it cannot re-halt the pipe
        go_d    = 5'b00001;
        clear_d = 4'b0001;
        state_d = RUN;
      end
    end
  end

  // State, registered halt flag and wrapping statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      cycle_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
      if (state_q == RUN) cycle_q <= cycle_q + CNT_ONE;
      if (do_stall)       stall_q <= stall_q + CNT_ONE;
      if (do_flush)       flush_q <= flush_q + CNT_ONE;
    end
  end

  assign {bus.go_pc, bus.go_if_id, bus.go_id_ex, bus.go_ex_mem, bus.go_mem_wb} = go_d;
  assign {bus.clear_if_id, bus.clear_id_ex, bus.clear_ex_mem, bus.clear_mem_wb} = clear_d;
  assign bus.halted    = halted_q;
  assign bus.cycle_cnt = cycle_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (4-bit counters so wrap is reachable).
// A driver applies one vector per cycle and queues the expected response;
// a monitor on the falling edge pops and compares it.
module tb_pipeline_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(W)) bus ();

  pipeline_ctrl #(.CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string      nm;
    logic [4:0] go;
    logic [3:0] clr;
    logic       h;
    logic [W-1:0] c;
    logic [W-1:0] s;
    logic [W-1:0] f;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Expected counter values as seen at the current sample point
  logic [W-1:0] acc_c, acc_s, acc_f;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is one transaction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] go_a;
      logic [3:0] clr_a;
      e = exp_q.pop_front();
      go_a  = {bus.go_pc, bus.go_if_id, bus.go_id_ex, bus.go_ex_mem, bus.go_mem_wb};
      clr_a = {bus.clear_if_id, bus.clear_id_ex, bus.clear_ex_mem, bus.clear_mem_wb};
      chk(e.nm, "go",     {3'b0, go_a},         {3'b0, e.go});
      chk(e.nm, "clear",  {4'b0, clr_a},        {4'b0, e.clr});
      chk(e.nm, "halted", {7'b0, bus.halted},   {7'b0, e.h});
      chk(e.nm, "cycle",  {4'b0, bus.cycle_cnt}, {4'b0, e.c});
      chk(e.nm, "stall",  {4'b0, bus.stall_cnt}, {4'b0, e.s});
      chk(e.nm, "flush",  {4'b0, bus.flush_cnt}, {4'b0, e.f});
      $display("txn %-10s go=%b clr=%b halted=%b cyc=%0d stall=%0d flush=%0d",
               e.nm, go_a, clr_a, bus.halted, bus.cycle_cnt, bus.stall_cnt, bus.flush_cnt);
    end
  end

  // One cycle: apply inputs, queue hand-computed response, advance counters
  task automatic step(input string nm, input logic r,
                      input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu,
                      input logic mr, input logic [4:0] rw,
                      input logic br, input logic bz, input logic sy, input logic re,
                      input logic [4:0] eg, input logic [3:0] ec, input logic eh,
                      input int dc, input int ds, input int df);
    exp_t e;
    rst                 = r;
    bus.id_rs           = rs;
    bus.id_rs_used      = rsu;
    bus.id_rt           = rt;
    bus.id_rt_used      = rtu;
    bus.ex_mem_read     = mr;
    bus.ex_rw           = rw;
    bus.ex_branch_taken = br;
    bus.mem_busy        = bz;
    bus.syscall_halt    = sy;
    bus.resume          = re;
    e.nm = nm; e.go = eg; e.clr = ec; e.h = eh;
    e.c = acc_c; e.s = acc_s; e.f = acc_f;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      acc_c = '0; acc_s = '0; acc_f = '0;
    end else begin
      acc_c = acc_c + W'(dc);
      acc_s = acc_s + W'(ds);
      acc_f = acc_f + W'(df);
    end
  endtask

  initial begin
    acc_c = '0; acc_s = '0; acc_f = '0;
    rst = 1'b1;
    bus.id_rs = 5'd0; bus.id_rs_used = 1'b0; bus.id_rt = 5'd0; bus.id_rt_used = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_rw = 5'd0; bus.ex_branch_taken = 1'b0;
    bus.mem_busy = 1'b0; bus.syscall_halt = 1'b0; bus.resume = 1'b0;
    @(posedge clk);
    #1;

    //        name        r  rs  rsu rt  rtu mr rw  br bz sy re  go        clr      h   dc ds df
    step("reset",      1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  0, 0, 0);
    for (int i = 0; i < 10; i++)
      step("idle",     0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("luse_rs",    0, 8,  1,  0,  0,  1, 8,  0, 0, 0, 0, 5'b00111, 4'b0100, 0,  1, 1, 0);
    step("load_r0",    0, 0,  1,  0,  0,  1, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("luse_rt",    0, 3,  0,  9,  1,  1, 9,  0, 0, 0, 0, 5'b00111, 4'b0100, 0,  1, 1, 0);
    step("rs_unused",  0, 8,  0,  2,  1,  1, 8,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("no_load",    0, 8,  1,  0,  0,  0, 8,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("br_luse",    0, 8,  1,  0,  0,  1, 8,  1, 0, 0, 0, 5'b11111, 4'b1100, 0,  1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("busy_luse",0, 8,  1,  0,  0,  1, 8,  0, 1, 0, 0, 5'b00000, 4'b0000, 0,  1, 0, 0);
    step("luse_after", 0, 8,  1,  0,  0,  1, 8,  0, 0, 0, 0, 5'b00111, 4'b0100, 0,  1, 1, 0);
    step("resume_run", 0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 1, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("sys_halt",   0, 8,  1,  0,  0,  1, 8,  1, 1, 1, 0, 5'b00000, 4'b0000, 0,  1, 0, 0);
    for (int i = 0; i < 5; i++)
      step("halted",   0, 8,  1,  0,  0,  1, 8,  1, 0, 1, 0, 5'b00000, 4'b0000, 1,  0, 0, 0);
    step("resume",     0, 0,  0,  0,  0,  0, 0,  0, 0, 1, 1, 5'b00001, 4'b0001, 1,  0, 0, 0);
    step("post_res",   0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("branch",     0, 0,  0,  0,  0,  0, 0,  1, 0, 0, 0, 5'b11111, 4'b1100, 0,  1, 0, 1);
    step("sys_halt2",  0, 0,  0,  0,  0,  0, 0,  0, 0, 1, 0, 5'b00000, 4'b0000, 0,  1, 0, 0);
    step("halted2",    0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b00000, 4'b0000, 1,  0, 0, 0);
    step("rst_halt",   1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 1,  0, 0, 0);
    step("after_rst",  0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);
    step("luse_pre",   0, 5,  1,  0,  0,  1, 5,  0, 0, 0, 0, 5'b00111, 4'b0100, 0,  1, 1, 0);
    step("rst_stall",  1, 5,  1,  0,  0,  1, 5,  0, 0, 0, 0, 5'b00111, 4'b0100, 0,  0, 0, 0);
    for (int i = 0; i < 16; i++)
      step("wrap_stall",0,7,  1,  0,  0,  1, 7,  0, 0, 0, 0, 5'b00111, 4'b0100, 0,  1, 1, 0);
    step("wrapped",    0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0, 5'b11111, 4'b0000, 0,  1, 0, 0);

    // Bounded drain of any outstanding expectations
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
